// File: rtl/pbus_rr_arbiter.sv
// Round-robin arbiter for the shared AXI-Lite peripheral bus.
// Holds a one-hot grant from address handshake until all responses complete; a watchdog reclaims stalled grants.
module pbus_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_WIDTH      = $clog2(NUM_MASTERS)
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [NUM_MASTERS-1:0] req_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_WIDTH-1:0]   gnt_idx_o,
  output logic                   gnt_valid_o,
  input  logic                   aw_hs_i,
  input  logic                   ar_hs_i,
  input  logic                   b_hs_i,
  input  logic                   r_hs_i,
  output logic                   timeout_o,
  output logic [IDX_WIDTH-1:0]   timeout_idx_o
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int WD_WIDTH = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_EN ? WD_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IDX_WIDTH-1:0] LAST_RESET = IDX_WIDTH'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_RESP
  } state_e;

  state_e                 r_state,      w_stateNext;
  logic                   r_pendB,      w_pendBNext;
  logic                   r_pendR,      w_pendRNext;
  logic [WD_WIDTH-1:0]    r_wdCnt,      w_wdNext;
  logic [NUM_MASTERS-1:0] r_gnt,        w_gntNext;
  logic [IDX_WIDTH-1:0]   r_gntIdx,     w_gntIdxNext;
  logic                   r_gntValid,   w_gntValidNext;
  logic [IDX_WIDTH-1:0]   r_lastIdx,    w_lastNext;
  logic                   r_timeout,    w_timeoutNext;
  logic [IDX_WIDTH-1:0]   r_timeoutIdx, w_timeoutIdxNext;
  logic [IDX_WIDTH-1:0]   w_winner;
  logic                   w_anyHs;
  logic                   w_wdExpire;

  function automatic logic [IDX_WIDTH-1:0] wrapIdx(input logic [IDX_WIDTH-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return IDX_WIDTH'(sum);
  endfunction

  // Scan from the farthest offset down so the nearest requester after last_idx wins.
  always_comb begin
    w_winner = r_lastIdx;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (req_i[wrapIdx(r_lastIdx, i)]) w_winner = wrapIdx(r_lastIdx, i);
    end
  end

  assign w_anyHs    = aw_hs_i | ar_hs_i | b_hs_i | r_hs_i;
  assign w_wdExpire = WD_EN && (r_wdCnt == WD_LAST) && !w_anyHs;

  always_comb begin
    w_stateNext      = r_state;
    w_pendBNext      = r_pendB;
    w_pendRNext      = r_pendR;
    w_wdNext         = r_wdCnt;
    w_gntNext        = r_gnt;
    w_gntIdxNext     = r_gntIdx;
    w_lastNext       = r_lastIdx;
    w_timeoutNext    = 1'b0;
    w_timeoutIdxNext = '0;
    case (r_state)
      IDLE: begin
        if (|req_i) begin
          w_stateNext  = GRANT;
          w_gntNext    = NUM_MASTERS'(1) << w_winner;
          w_gntIdxNext = w_winner;
          w_lastNext   = w_winner;
          w_wdNext     = '0;
        end
      end
      GRANT, WAIT_RESP: begin
        // A new address handshake takes priority over a same-cycle response.
        w_pendBNext = aw_hs_i | (r_pendB & ~b_hs_i);
        w_pendRNext = ar_hs_i | (r_pendR & ~r_hs_i);
        if (w_anyHs || !WD_EN) w_wdNext = '0;
        else                   w_wdNext = r_wdCnt + WD_WIDTH'(1);
        if (w_wdExpire) begin
          w_stateNext      = IDLE;
          w_pendBNext      = 1'b0;
          w_pendRNext      = 1'b0;
          w_wdNext         = '0;
          w_gntNext        = '0;
          w_gntIdxNext     = '0;
          w_timeoutNext    = 1'b1;
          w_timeoutIdxNext = r_gntIdx;
        end else if (r_state == GRANT) begin
          if (aw_hs_i || ar_hs_i) w_stateNext = WAIT_RESP;
        end else if (!w_pendBNext && !w_pendRNext) begin
          w_stateNext  = IDLE;
          w_wdNext     = '0;
          w_gntNext    = '0;
          w_gntIdxNext = '0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    w_gntValidNext = (w_stateNext != IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= IDLE;
      r_pendB      <= 1'b0;
      r_pendR      <= 1'b0;
      r_wdCnt      <= '0;
      r_gnt        <= '0;
      r_gntIdx     <= '0;
      r_gntValid   <= 1'b0;
      r_lastIdx    <= LAST_RESET;
      r_timeout    <= 1'b0;
      r_timeoutIdx <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_pendB      <= w_pendBNext;
      r_pendR      <= w_pendRNext;
      r_wdCnt      <= w_wdNext;
      r_gnt        <= w_gntNext;
      r_gntIdx     <= w_gntIdxNext;
      r_gntValid   <= w_gntValidNext;
      r_lastIdx    <= w_lastNext;
      r_timeout    <= w_timeoutNext;
      r_timeoutIdx <= w_timeoutIdxNext;
    end
  end

  assign gnt_o         = r_gnt;
  assign gnt_idx_o     = r_gntIdx;
  assign gnt_valid_o   = r_gntValid;
  assign timeout_o     = r_timeout;
  assign timeout_idx_o = r_timeoutIdx;

endmodule

// File: tb/tb_pbus_rr_arbiter.sv
// Scoreboard bench for pbus_rr_arbiter: each driven cycle pushes the outputs expected after the next edge.
module tb_pbus_rr_arbiter;

  logic       clock_i;
  logic       reset_ni;
  logic [1:0] req_i;
  logic [1:0] gnt_o;
  logic [0:0] gnt_idx_o;
  logic       gnt_valid_o;
  logic       aw_hs_i, ar_hs_i, b_hs_i, r_hs_i;
  logic       timeout_o;
  logic [0:0] timeout_idx_o;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string    tag;
    logic [1:0] gnt;
    logic     to;
    logic     toIdx;
  } exp_t;

  exp_t expQ[$];

  pbus_rr_arbiter #(
    .NUM_MASTERS(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock_i(clock_i),
    .reset_ni(reset_ni),
    .req_i(req_i),
    .gnt_o(gnt_o),
    .gnt_idx_o(gnt_idx_o),
    .gnt_valid_o(gnt_valid_o),
    .aw_hs_i(aw_hs_i),
    .ar_hs_i(ar_hs_i),
    .b_hs_i(b_hs_i),
    .r_hs_i(r_hs_i),
    .timeout_o(timeout_o),
    .timeout_idx_o(timeout_idx_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareCycle();
    exp_t e;
    checkOutput("queue_depth", expQ.size(), 1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.tag, ".gnt"}, gnt_o, e.gnt);
      checkOutput({e.tag, ".idx"}, gnt_idx_o, (e.gnt == 2'b10) ? 1 : 0);
      checkOutput({e.tag, ".valid"}, gnt_valid_o, (e.gnt != 2'b00) ? 1 : 0);
      checkOutput({e.tag, ".timeout"}, timeout_o, e.to);
      checkOutput({e.tag, ".timeout_idx"}, timeout_idx_o, e.toIdx);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic aw, input logic ar, input logic b,
                               input logic r, input logic [1:0] expGnt, input logic expTo,
                               input logic expToIdx, input string tag);
    exp_t e;
    req_i   = req;
    aw_hs_i = aw;
    ar_hs_i = ar;
    b_hs_i  = b;
    r_hs_i  = r;
    e.tag   = tag;
    e.gnt   = expGnt;
    e.to    = expTo;
    e.toIdx = expToIdx;
    expQ.push_back(e);
    @(posedge clock_i);
    #1;
    compareCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] run aborted");
  end

  initial begin
    exp_t e;
    logic [1:0] g;
    reset_ni = 1'b0;
    req_i    = 2'b00;
    aw_hs_i  = 1'b0;
    ar_hs_i  = 1'b0;
    b_hs_i   = 1'b0;
    r_hs_i   = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    e = '{tag: "reset", gnt: 2'b00, to: 1'b0, toIdx: 1'b0};
    expQ.push_back(e);
    compareCycle();
    reset_ni = 1'b1;

    // Single requester: grant, read transaction, release, regrant.
    applyStimulus(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, "single_grant");
    applyStimulus(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, "single_hold1");
    applyStimulus(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, "single_hold2");
    applyStimulus(2'b01, 0, 1, 0, 0, 2'b01, 0, 0, "single_ar");
    applyStimulus(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, "single_wait");
    applyStimulus(2'b01, 0, 0, 0, 1, 2'b00, 0, 0, "single_release");
    applyStimulus(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, "single_regrant");
    applyStimulus(2'b01, 1, 0, 0, 0, 2'b01, 0, 0, "single_aw");
    applyStimulus(2'b01, 0, 0, 1, 0, 2'b00, 0, 0, "single_b_release");
    applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, "idle_noreq");

    // Handshakes in IDLE and a spurious B in GRANT must leave no pending flag behind.
    applyStimulus(2'b00, 1, 1, 0, 0, 2'b00, 0, 0, "idle_hs_ignored");
    applyStimulus(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, "spur_grant");
    applyStimulus(2'b01, 0, 0, 1, 0, 2'b01, 0, 0, "spur_b_in_grant");
    applyStimulus(2'b01, 1, 0, 0, 0, 2'b01, 0, 0, "spur_aw");
    applyStimulus(2'b01, 0, 0, 0, 0, 2'b01, 0, 0, "spur_wait");
    applyStimulus(2'b01, 0, 0, 1, 0, 2'b00, 0, 0, "spur_b_release");
    applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, "spur_idle");

    // Dual outstanding on master 1: release only after the later R.
    applyStimulus(2'b11, 0, 0, 0, 0, 2'b10, 0, 0, "dual_grant_m1");
    applyStimulus(2'b11, 1, 1, 0, 0, 2'b10, 0, 0, "dual_aw_ar");
    applyStimulus(2'b11, 0, 0, 0, 0, 2'b10, 0, 0, "dual_wait1");
    applyStimulus(2'b11, 0, 0, 1, 0, 2'b10, 0, 0, "dual_b_holds");
    applyStimulus(2'b11, 0, 0, 0, 0, 2'b10, 0, 0, "dual_wait2");
    applyStimulus(2'b11, 0, 0, 0, 1, 2'b00, 0, 0, "dual_r_release");
    applyStimulus(2'b11, 0, 0, 0, 0, 2'b01, 0, 0, "rr_m0");
    applyStimulus(2'b11, 1, 0, 0, 0, 2'b01, 0, 0, "rr_m0_aw");
    applyStimulus(2'b11, 0, 0, 0, 0, 2'b01, 0, 0, "rr_m0_wait");
    applyStimulus(2'b11, 0, 0, 1, 0, 2'b00, 0, 0, "rr_m0_release");
    applyStimulus(2'b11, 0, 0, 0, 0, 2'b10, 0, 0, "rr_m1");
    applyStimulus(2'b11, 0, 1, 0, 0, 2'b10, 0, 0, "rr_m1_ar");

    // Asynchronous reset mid WAIT_RESP with master 1 granted.
    e = '{tag: "async_reset", gnt: 2'b00, to: 1'b0, toIdx: 1'b0};
    expQ.push_back(e);
    #3;
    reset_ni = 1'b0;
    #1;
    compareCycle();
    @(posedge clock_i);
    #1;
    reset_ni = 1'b1;

    // Contention after reset: master 0 first, then strict alternation.
    for (int m = 0; m < 4; m++) begin
      g = (m % 2 == 0) ? 2'b01 : 2'b10;
      applyStimulus(2'b11, 0, 0, 0, 0, g, 0, 0, $sformatf("cont%0d_grant", m));
      applyStimulus(2'b11, 1, 0, 0, 0, g, 0, 0, $sformatf("cont%0d_aw", m));
      applyStimulus(2'b11, 0, 0, 0, 0, g, 0, 0, $sformatf("cont%0d_wait", m));
      applyStimulus(2'b11, 0, 0, 1, 0, 2'b00, 0, 0, $sformatf("cont%0d_release", m));
    end

    // Watchdog: each stalled grant lasts 8 cycles, then a one-cycle timeout pulse.
    for (int m = 0; m < 2; m++) begin
      g = (m == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k < 8; k++)
        applyStimulus(2'b11, 0, 0, 0, 0, g, 0, 0, $sformatf("wd_m%0d_held%0d", m, k));
      applyStimulus(2'b11, 0, 0, 0, 0, 2'b00, 1, m[0], $sformatf("wd_m%0d_timeout", m));
    end
    applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, "wd_pulse_end");
    applyStimulus(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
